// File: rtl/btb_predictor.sv
// -----------------------------------------------------------------------------
// btb_predictor
//
// Tagged, direct-mapped branch target buffer with a saturating direction
// counter per entry. The fetch stage queries it combinationally with its
// current fetch address. The memory stage writes back resolved branches.
// A small sweep state machine invalidates the whole table after reset and
// whenever the pipeline requests a flush. Two saturating performance counters
// track qualified lookups and reported mispredicts.
//
// Address split: index = pc[IDX_W+1:2], tag = pc[ADDR_W-1:IDX_W+2].
//
// Ports:
//   CLK              clock, all state updates on the rising edge
//   nRST             synchronous active-low reset
//   lookup_en        fetch stage advancing this cycle (qualifies stat_lookups)
//   lookup_pc        fetch address
//   pred_hit         valid tag match at lookup_pc
//   pred_taken       predict taken
//   pred_target      predicted next fetch address
//   pred_index       table index of lookup_pc, carried down the pipe
//   upd_valid        resolved branch presented this cycle
//   upd_pc           address of the resolved branch
//   upd_taken        actual branch outcome
//   upd_target       actual branch target
//   upd_mispredict   pipeline detected a mispredict for this branch
//   flush            request full invalidation
//   busy             invalidation sweep in progress
//   stat_lookups     qualified lookups (saturating)
//   stat_mispredicts reported mispredicts (saturating)
// -----------------------------------------------------------------------------
module btb_predictor #(
    parameter  int ENTRIES  = 16,
    parameter  int CNT_BITS = 2,
    parameter  int ADDR_W   = 32,
    parameter  int STAT_W   = 32,
    localparam int IDX_W    = $clog2(ENTRIES)
) (
    input  logic              CLK,
    input  logic              nRST,

    input  logic              lookup_en,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    output logic [IDX_W-1:0]  pred_index,

    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_mispredict,

    input  logic              flush,
    output logic              busy,

    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int TAG_W = ADDR_W - IDX_W - 2;

    // Counter encodings: MSB set means predict taken.
    localparam logic [CNT_BITS-1:0] CNT_MAX     = '1;
    localparam logic [CNT_BITS-1:0] CNT_WEAK_T  = CNT_BITS'(1 << (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0] CNT_WEAK_NT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);

    typedef enum logic {
        CLEAR,
        READY
    } sweepState_t;

    // -------------------------------------------------------------------------
    // Table storage
    // -------------------------------------------------------------------------
    logic                validQ  [ENTRIES];
    logic [TAG_W-1:0]    tagQ    [ENTRIES];
    logic [ADDR_W-1:0]   targetQ [ENTRIES];
    logic [CNT_BITS-1:0] cntQ    [ENTRIES];

    // -------------------------------------------------------------------------
    // Sweep state machine
    // -------------------------------------------------------------------------
    sweepState_t      stateQ, stateD;
    logic [IDX_W-1:0] sweepIdxQ, sweepIdxD;
    logic             sweepWr;

    assign busy = (stateQ == CLEAR);

    // NOTE: every signal driven here gets a default first so no path through
    // the case leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        stateD    = stateQ;
        sweepIdxD = sweepIdxQ;
        sweepWr   = 1'b0;
        case (stateQ)
            CLEAR: begin
                sweepWr = 1'b1;
                if (flush) begin
                    // A flush mid-sweep restarts from the first entry.
                    sweepIdxD = '0;
                end else if (sweepIdxQ == IDX_W'(ENTRIES - 1)) begin
                    stateD    = READY;
                    sweepIdxD = '0;
                end else begin
                    sweepIdxD = sweepIdxQ + 1'b1;
                end
            end
            READY: begin
                if (flush) begin
                    stateD    = CLEAR;
                    sweepIdxD = '0;
                end
            end
            default: begin
                stateD    = CLEAR;
                sweepIdxD = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Lookup path (purely combinational, sees pre-update contents)
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0]  lookupIdx;
    logic [TAG_W-1:0]  lookupTag;
    logic [ADDR_W-1:0] lookupNext;

    assign lookupIdx  = lookup_pc[IDX_W+1:2];
    assign lookupTag  = lookup_pc[ADDR_W-1:IDX_W+2];
    assign lookupNext = lookup_pc + ADDR_W'(4);

    always_comb begin
        pred_index  = lookupIdx;
        pred_hit    = !busy && validQ[lookupIdx] && (tagQ[lookupIdx] == lookupTag);
        pred_taken  = pred_hit && cntQ[lookupIdx][CNT_BITS-1];
        pred_target = pred_taken ? targetQ[lookupIdx] : lookupNext;
    end

    // -------------------------------------------------------------------------
    // Update path
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0]    updIdx;
    logic [TAG_W-1:0]    updTag;
    logic                updHit;
    logic                updEn;
    logic [CNT_BITS-1:0] updCnt;
    logic [CNT_BITS-1:0] cntNext;
    logic                unusedUpdBits;

    assign updIdx        = upd_pc[IDX_W+1:2];
    assign updTag        = upd_pc[ADDR_W-1:IDX_W+2];
    assign updHit        = validQ[updIdx] && (tagQ[updIdx] == updTag);
    assign updCnt        = cntQ[updIdx];
    // Reset and flush both take precedence over a resolved branch; while the
    // sweep runs the table is owned by the sweep and updates are dropped.
    assign updEn         = nRST && upd_valid && !busy && !flush;
    assign unusedUpdBits = ^upd_pc[1:0];

    always_comb begin
        cntNext = updCnt;
        if (upd_taken) begin
            if (updCnt != CNT_MAX) cntNext = updCnt + 1'b1;
        end else begin
            if (updCnt != '0) cntNext = updCnt - 1'b1;
        end
    end

    // Valid bits are the only table state that reset must touch; a cleared
    // valid bit makes tag, target and counter contents irrelevant.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) validQ[i] <= 1'b0;
        end else if (sweepWr) begin
            validQ[sweepIdxQ] <= 1'b0;
        end else if (updEn && !updHit && upd_taken) begin
            validQ[updIdx] <= 1'b1;
        end
    end

    // NOTE: tag/target/counter arrays are deliberately not reset; they are
    // qualified by validQ, and leaving them reset-free lets them map to RAM.
    always_ff @(posedge CLK) begin
        if (sweepWr) begin
            cntQ[sweepIdxQ] <= CNT_WEAK_NT;
        end else if (updEn) begin
            if (updHit) begin
                cntQ[updIdx] <= cntNext;
                if (upd_taken) targetQ[updIdx] <= upd_target;
            end else if (upd_taken) begin
                tagQ[updIdx]    <= updTag;
                targetQ[updIdx] <= upd_target;
                cntQ[updIdx]    <= CNT_WEAK_T;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register and statistics
    // -------------------------------------------------------------------------
    logic [STAT_W-1:0] statLookupsQ;
    logic [STAT_W-1:0] statMispredictsQ;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stateQ           <= CLEAR;
            sweepIdxQ        <= '0;
            statLookupsQ     <= '0;
            statMispredictsQ <= '0;
        end else begin
            stateQ    <= stateD;
            sweepIdxQ <= sweepIdxD;
            if (lookup_en && !busy && (statLookupsQ != '1))
                statLookupsQ <= statLookupsQ + 1'b1;
            // Mispredicts are counted even while the table is being swept.
            if (upd_valid && upd_mispredict && (statMispredictsQ != '1))
                statMispredictsQ <= statMispredictsQ + 1'b1;
        end
    end

    assign stat_lookups     = statLookupsQ;
    assign stat_mispredicts = statMispredictsQ;

endmodule

// File: tb/tb_btb_predictor.sv
// -----------------------------------------------------------------------------
// tb_btb_predictor
//
// Directed testbench for btb_predictor (ENTRIES=16, CNT_BITS=2, ADDR_W=32).
// The stimulus process drives one cycle at a time and pushes the expected
// outputs for that cycle into a scoreboard queue; the monitor pops and
// compares on the falling edge whenever a sample is pending.
// -----------------------------------------------------------------------------
module tb_btb_predictor;

    localparam int ENTRIES  = 16;
    localparam int CNT_BITS = 2;
    localparam int ADDR_W   = 32;
    localparam int STAT_W   = 32;
    localparam int IDX_W    = $clog2(ENTRIES);

    logic              CLK = 1'b0;
    logic              nRST;
    logic              lookup_en;
    logic [ADDR_W-1:0] lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic [IDX_W-1:0]  pred_index;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_mispredict;
    logic              flush;
    logic              busy;
    logic [STAT_W-1:0] stat_lookups;
    logic [STAT_W-1:0] stat_mispredicts;

    btb_predictor #(
        .ENTRIES (ENTRIES),
        .CNT_BITS(CNT_BITS),
        .ADDR_W  (ADDR_W),
        .STAT_W  (STAT_W)
    ) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .lookup_en       (lookup_en),
        .lookup_pc       (lookup_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .pred_index      (pred_index),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_mispredict  (upd_mispredict),
        .flush           (flush),
        .busy            (busy),
        .stat_lookups    (stat_lookups),
        .stat_mispredicts(stat_mispredicts)
    );

    always #5 CLK = ~CLK;

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    typedef struct {
        string       name;
        logic        busy;
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic [3:0]  idx;
        logic        chkStats;
        logic [31:0] lookups;
        logic [31:0] mispredicts;
    } expect_t;

    expect_t sbQ[$];
    expect_t cur;
    logic    sampleReq = 1'b0;
    logic    endReq    = 1'b0;
    int      vecCount  = 0;
    int      missCount = 0;

    always @(negedge CLK) begin
        if (sampleReq) begin
            vecCount++;
            if (sbQ.size() == 0) begin
                missCount++;
                $display("FAIL scoreboard_underflow: sample requested with empty queue");
            end else begin
                cur = sbQ.pop_front();
                if ((busy !== cur.busy) || (pred_hit !== cur.hit) ||
                    (pred_taken !== cur.taken) || (pred_target !== cur.target) ||
                    (pred_index !== cur.idx) ||
                    (cur.chkStats && ((stat_lookups !== cur.lookups) ||
                                      (stat_mispredicts !== cur.mispredicts)))) begin
                    missCount++;
                    $display("FAIL %s: got busy=%b hit=%b taken=%b target=%h idx=%0d lk=%0d mp=%0d, want busy=%b hit=%b taken=%b target=%h idx=%0d lk=%0d mp=%0d (stats %s)",
                             cur.name, busy, pred_hit, pred_taken, pred_target, pred_index,
                             stat_lookups, stat_mispredicts,
                             cur.busy, cur.hit, cur.taken, cur.target, cur.idx,
                             cur.lookups, cur.mispredicts, cur.chkStats ? "checked" : "ignored");
                end
            end
        end
        if (endReq) begin
            vecCount++;
            if (sbQ.size() != 0) begin
                missCount++;
                $display("FAIL scoreboard_drain: %0d entries left, want 0", sbQ.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge CLK);
        #1;
        sampleReq      = 1'b0;
        upd_valid      = 1'b0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic expFull(input string n, input logic b, input logic h, input logic t,
                           input logic [31:0] tgt, input logic cs,
                           input logic [31:0] lk, input logic [31:0] mp);
        expect_t e;
        e.name        = n;
        e.busy        = b;
        e.hit         = h;
        e.taken       = t;
        e.target      = tgt;
        e.idx         = lookup_pc[5:2];
        e.chkStats    = cs;
        e.lookups     = lk;
        e.mispredicts = mp;
        sbQ.push_back(e);
        sampleReq = 1'b1;
    endtask

    task automatic expPred(input string n, input logic b, input logic h, input logic t,
                           input logic [31:0] tgt);
        expFull(n, b, h, t, tgt, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic mp);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_mispredict = mp;
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        nRST = 1'b0; lookup_en = 1'b0; lookup_pc = 32'h0;
        upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
        upd_target = 32'h0; upd_mispredict = 1'b0; flush = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Reset release: busy for 16 cycles, then a clean miss with zero stats.
        lookup_pc = 32'h100;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) expFull("rst_busy", 1, 0, 0, 32'h104, 1, 0, 0);
            else        expPred("rst_busy", 1, 0, 0, 32'h104);
            tick();
        end
        expFull("rst_done", 0, 0, 0, 32'h104, 1, 0, 0); tick();

        // Allocation at 0x40 (index 0), counter becomes weakly taken.
        lookup_pc = 32'h40;
        upd(32'h40, 1, 32'h80, 0); expPred("alloc_pre", 0, 0, 0, 32'h44); tick();
        expPred("alloc_hit", 0, 1, 1, 32'h80); tick();

        // Saturate upward: 2 -> 3 -> 3 -> 3.
        for (int i = 0; i < 3; i++) begin
            upd(32'h40, 1, 32'h80, 0); expPred("sat_up", 0, 1, 1, 32'h80); tick();
        end
        // Two not-taken: 3 -> 2 -> 1; the taken target must not change.
        for (int i = 0; i < 2; i++) begin
            upd(32'h40, 0, 32'h3C0, 0); expPred("dec_pre", 0, 1, 1, 32'h80); tick();
        end
        expPred("weak_nt", 0, 1, 0, 32'h44); tick();
        // Saturate downward: 1 -> 0 -> 0 -> 0.
        for (int i = 0; i < 3; i++) begin
            upd(32'h40, 0, 32'h3C0, 0); expPred("sat_down", 0, 1, 0, 32'h44); tick();
        end
        // Two taken with a new target: 0 -> 1 -> 2.
        for (int i = 0; i < 2; i++) begin
            upd(32'h40, 1, 32'h88, 0); expPred("inc_pre", 0, 1, 0, 32'h44); tick();
        end
        expPred("retaken", 0, 1, 1, 32'h88); tick();

        // Same-cycle lookup/update: lookup sees counter 2, then 1.
        upd(32'h40, 0, 32'h0, 0); expPred("hazard_same", 0, 1, 1, 32'h88); tick();
        expPred("hazard_next", 0, 1, 0, 32'h44); tick();

        // Aliasing at index 0: 0x80 replaces 0x40.
        lookup_pc = 32'h80;
        upd(32'h80, 1, 32'h200, 0); expPred("alias_miss", 0, 0, 0, 32'h84); tick();
        expPred("alias_alloc", 0, 1, 1, 32'h200); tick();
        lookup_pc = 32'h40;
        expPred("alias_evict", 0, 0, 0, 32'h44); tick();
        // Not-taken update at an unallocated pc leaves the table unchanged.
        lookup_pc = 32'h1004;
        upd(32'h1004, 0, 32'h2000, 0); expPred("nt_miss_pre", 0, 0, 0, 32'h1008); tick();
        expPred("nt_miss_post", 0, 0, 0, 32'h1008); tick();
        lookup_pc = 32'h80;
        expPred("alias_kept", 0, 1, 1, 32'h200); tick();

        // Qualified lookups.
        lookup_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expPred("lk_count", 0, 1, 1, 32'h200); tick();
        end
        lookup_en = 1'b0;
        expFull("lk_stat", 0, 1, 1, 32'h200, 1, 3, 0); tick();

        // Flush in READY; prediction unaffected this cycle, coinciding update dropped.
        lookup_en = 1'b1; flush = 1'b1;
        upd(32'h300, 1, 32'h400, 1);
        expFull("flush_cycle", 0, 1, 1, 32'h200, 1, 3, 0); tick();
        // First sweep, restarted by a second flush while sweep_idx=7.
        for (int i = 0; i < 8; i++) begin
            if (i == 7) flush = 1'b1;
            if (i == 0) expFull("busy_first", 1, 0, 0, 32'h84, 1, 4, 1);
            else        expPred("busy_first", 1, 0, 0, 32'h84);
            tick();
        end
        lookup_en = 1'b0;
        // Restarted sweep: a full 16 cycles, with an update that must be dropped.
        for (int j = 0; j < 16; j++) begin
            if (j == 5) upd(32'h504, 1, 32'h600, 1);
            if (j == 15) expFull("busy_restart", 1, 0, 0, 32'h84, 1, 4, 2);
            else         expPred("busy_restart", 1, 0, 0, 32'h84);
            tick();
        end
        expPred("post_flush_80", 0, 0, 0, 32'h84); tick();
        lookup_pc = 32'h40;
        expPred("post_flush_40", 0, 0, 0, 32'h44); tick();
        lookup_pc = 32'h504;
        expPred("busy_upd_dropped", 0, 0, 0, 32'h508); tick();

        // Three more mispredict pulses in READY (5 in total).
        lookup_pc = 32'h1004;
        for (int i = 0; i < 3; i++) begin
            upd(32'h1004, 0, 32'h0, 1); expPred("mis_pulse", 0, 0, 0, 32'h1008); tick();
        end
        expFull("final_stats", 0, 0, 0, 32'h1008, 1, 4, 5); tick();

        endReq = 1'b1;
    end

endmodule
